// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the subordinate control state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/ahb_addr_check.sv
// Flags an address phase that this slave cannot serve: oversized transfer,
// misaligned half/word, or an address outside the slave window.
module ahb_addr_check
   import ahb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                WIN_BYTES = 4096
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_size,
   output logic              o_err
);

   localparam logic [ADDR_W:0] WIN = (ADDR_W+1)'(WIN_BYTES);

   logic [ADDR_W:0] w_off;
   logic            w_bad_size;
   logic            w_misalign;
   logic            w_out_of_range;

   // Extra top bit turns an address below the base into a huge offset.
   assign w_off          = {1'b0, i_addr} - {1'b0, BASE_ADDR};
   assign w_out_of_range = (w_off >= WIN);
   assign w_bad_size     = (i_size > HSIZE_WORD);

   always_comb begin
      w_misalign = 1'b0;
      case (i_size)
         HSIZE_HALF: w_misalign = i_addr[0];
         HSIZE_WORD: w_misalign = |i_addr[1:0];
         default:    w_misalign = 1'b0;
      endcase
   end

   assign o_err = w_bad_size || w_misalign || w_out_of_range;

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite subordinate control: captures address phases, forwards them to a
// request/ready backend and returns OKAY or the two-cycle ERROR response.
//
// state     | meaning
// ST_IDLE   | no transfer in data phase, ready for a capture
// ST_ACCESS | request held on the backend, wait states inserted
// ST_DONE   | OKAY completion cycle, pipelined capture allowed
// ST_ERR1   | first ERROR cycle (HREADYOUT low)
// ST_ERR2   | second ERROR cycle (HREADYOUT high), capture allowed
module ahb_slave_ctrl
   import ahb_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                WIN_BYTES = 4096,
   parameter int                TIMEOUT   = 15
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [DATA_W-1:0] HRDATA,
   output logic              req_valid,
   output logic              req_write,
   output logic [ADDR_W-1:0] req_addr,
   output logic [2:0]        req_size,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              req_ready,
   input  logic [DATA_W-1:0] rsp_rdata,
   input  logic              rsp_err
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_cnt;
   logic [7:0]        w_cnt_inc;
   logic [DATA_W-1:0] r_hrdata;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_size;
   logic              w_cap;
   logic              w_cap_ok;
   logic              w_addr_err;
   logic              w_timeout;

   ahb_addr_check #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .WIN_BYTES (WIN_BYTES)
   ) u_addr_check (
      .i_addr (HADDR),
      .i_size (HSIZE),
      .o_err  (w_addr_err)
   );

   assign w_cap     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign w_cap_ok  = w_cap && (r_state inside {ST_IDLE, ST_DONE, ST_ERR2});
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

   always_comb begin
      w_state_nxt = r_state;
      HREADYOUT   = 1'b1;
      HRESP       = HRESP_OKAY;
      req_valid   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (r_state == ST_ERR2) HRESP = HRESP_ERROR;
            if (w_cap_ok) w_state_nxt = w_addr_err ? ST_ERR1 : ST_ACCESS;
            else          w_state_nxt = ST_IDLE;
         end
         ST_ACCESS: begin
            HREADYOUT = 1'b0;
            req_valid = 1'b1;
            // A response on the timeout cycle still completes the transfer.
            if (req_ready)      w_state_nxt = rsp_err ? ST_ERR1 : ST_DONE;
            else if (w_timeout) w_state_nxt = ST_ERR1;
         end
         ST_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = HRESP_ERROR;
            w_state_nxt = ST_ERR2;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hrdata <= '0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_size   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap_ok) begin
            r_cnt   <= '0;
            r_write <= HWRITE;
            r_addr  <= HADDR;
            r_size  <= HSIZE;
         end else if (r_state == ST_ACCESS) begin
            r_cnt <= w_cnt_inc;
         end
         if (r_state == ST_ACCESS && req_ready && !rsp_err && !r_write)
            r_hrdata <= rsp_rdata;
      end
   end

   assign HRDATA    = r_hrdata;
   assign req_write = r_write;
   assign req_addr  = r_addr;
   assign req_size  = r_size;
   assign req_wdata = HWDATA;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Self-checking bench for ahb_slave_ctrl: table vectors, random transfers
// against a transaction-level model, bursts, reset mid-burst, stray ready.
`timescale 1ns/1ps
module tb_ahb_slave_ctrl;
   import ahb_pkg::*;

   localparam logic [31:0] BASE    = 32'h4000_0000;
   localparam int          WIN     = 4096;
   localparam int          TIMEOUT = 15;
   localparam logic [31:0] RD_KEY  = 32'hA5C3_0F96;
   localparam logic [31:0] WD_KEY  = 32'h1111_0000;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_hrdata = '0;

   int          be_dly = 0;
   logic        be_err = 1'b0;
   logic [31:0] be_rdata = '0;
   logic        be_stray = 1'b0;
   int          be_cnt = 0;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb_slave_ctrl #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .BASE_ADDR (BASE),
      .WIN_BYTES (WIN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  sz;
      int          dly;
      logic        berr;
      logic        fault;
      int          lo;
      int          req;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Backend: answers be_dly cycles into a request, noise otherwise.
   initial begin
      req_ready = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      forever begin
         @(posedge HCLK);
         #1;
         if (req_valid) begin
            if (be_cnt == be_dly) begin
               req_ready = 1'b1;
               rsp_rdata = be_rdata;
               rsp_err   = be_err;
            end else begin
               req_ready = 1'b0;
               rsp_rdata = $urandom;
               rsp_err   = 1'($urandom);
            end
            be_cnt++;
         end else begin
            req_ready = be_stray;
            rsp_rdata = be_stray ? 32'hBAD0_BAD0 : 32'h0;
            rsp_err   = 1'b0;
            be_cnt    = 0;
         end
      end
   end

   // Transaction-level expectation from the slave's rules.
   function automatic void model(input logic [31:0] addr, input logic [2:0] sz, input int dly,
                                 input logic berr, output logic fault, output int lo, output int nreq);
      longint a;
      bit     bad;
      a   = longint'(addr);
      bad = (sz > 3'd2) || (a < longint'(BASE)) || (a >= longint'(BASE) + WIN);
      if (!bad && (a % (longint'(1) << sz)) != 0) bad = 1;
      if (bad) begin
         fault = 1'b1;
         lo    = 1;
         nreq  = 0;
      end else begin
         nreq  = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
         fault = (dly >= TIMEOUT) || berr;
         lo    = nreq + (fault ? 1 : 0);
      end
   endfunction

   task automatic rst_checks(input string tag);
      chk({tag, "_hreadyout"}, {31'b0, HREADYOUT}, 32'd1);
      chk({tag, "_hresp"},     {31'b0, HRESP},     32'd0);
      chk({tag, "_hrdata"},    HRDATA,             32'd0);
      chk({tag, "_req_valid"}, {31'b0, req_valid}, 32'd0);
      chk({tag, "_req_write"}, {31'b0, req_write}, 32'd0);
      chk({tag, "_req_addr"},  req_addr,           32'd0);
      chk({tag, "_req_size"},  {29'b0, req_size},  32'd0);
   endtask

   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input int dly, input logic berr,
                       input logic exp_fault, input int exp_lo, input int exp_req);
      int   lo = 0;
      int   nreq = 0;
      int   nresp = 0;
      logic fin_resp = 1'b0;
      bit   ok = 0;
      be_dly   = dly;
      be_err   = berr;
      be_rdata = addr ^ RD_KEY;
      @(posedge HCLK);
      #1;
      HSEL = 1'b1; HADDR = addr; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HSIZE = sz;
      @(posedge HCLK);
      #1;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wd; HADDR = $urandom; HWRITE = 1'($urandom);
      for (int c = 0; c < 300; c++) begin
         @(negedge HCLK);
         if (req_valid) begin
            nreq++;
            chk("req_addr",  req_addr,             addr);
            chk("req_write", {31'b0, req_write},   {31'b0, wr});
            chk("req_size",  {29'b0, req_size},    {29'b0, sz});
            chk("req_wdata", req_wdata,            wd);
         end
         if (HRESP) nresp++;
         if (HREADYOUT) begin
            fin_resp = HRESP;
            ok = 1;
            break;
         end
         lo++;
      end
      if (!ok) chk("xfer_completes", 32'd0, 32'd1);
      chk("wait_cycles",  32'(lo),             32'(exp_lo));
      chk("req_cycles",   32'(nreq),           32'(exp_req));
      chk("final_hresp",  {31'b0, fin_resp},   {31'b0, exp_fault});
      chk("error_cycles", 32'(nresp),          exp_fault ? 32'd2 : 32'd0);
      if (!wr && !exp_fault) exp_hrdata = addr ^ RD_KEY;
      chk("hrdata", HRDATA, exp_hrdata);
   endtask

   // Pipelined INCR4 word burst; rst_beat>0 pulses reset during that beat's ACCESS.
   task automatic burst(input logic wr, input logic [31:0] a0, input int rst_beat);
      int nreq = 0;
      int lo = 0;
      int b = 0;
      bit hr;
      be_dly = 0;
      be_err = 1'b0;
      @(posedge HCLK);
      #1;
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a0; HWRITE = wr; HSIZE = HSIZE_WORD;
      for (int c = 0; c < 12; c++) begin
         @(negedge HCLK);
         if (req_valid) begin
            chk("burst_req_addr",  req_addr,  a0 + 32'(4 * nreq));
            chk("burst_req_cycle", 32'(c),    32'(2 * nreq + 1));
            if (wr) chk("burst_wdata", req_wdata, WD_KEY + 32'(nreq));
            nreq++;
            if (nreq == rst_beat) begin
               #2 HRESETn = 1'b0;
               #1 rst_checks("midburst_reset");
               HSEL = 1'b0; HTRANS = HTRANS_IDLE;
               exp_hrdata = '0;
               @(posedge HCLK);
               #1 HRESETn = 1'b1;
               return;
            end
         end
         chk("burst_hresp", {31'b0, HRESP}, 32'd0);
         hr = HREADYOUT;
         if (!hr) lo++;
         @(posedge HCLK);
         #1;
         if (hr) begin
            if (b < 4) begin
               HWDATA = WD_KEY + 32'(b);
               b++;
            end
            if (b < 4) begin
               HTRANS = HTRANS_SEQ;
               HADDR  = a0 + 32'(4 * b);
            end else begin
               HSEL   = 1'b0;
               HTRANS = HTRANS_IDLE;
            end
         end
      end
      chk("burst_reqs",        32'(nreq), 32'd4);
      chk("burst_wait_cycles", 32'(lo),   32'd4);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[13];
      logic        m_fault;
      int          m_lo;
      int          m_req;
      logic [31:0] a;
      logic [2:0]  sz;
      int          dly;
      logic        berr;

      tbl[0]  = '{BASE + 32'h010, 1'b1, HSIZE_WORD, 0,  1'b0, 1'b0, 1,  1};
      tbl[1]  = '{BASE + 32'h020, 1'b0, HSIZE_WORD, 2,  1'b0, 1'b0, 3,  3};
      tbl[2]  = '{BASE + 32'h002, 1'b0, HSIZE_WORD, 0,  1'b0, 1'b1, 1,  0};
      tbl[3]  = '{BASE + 32'h1000, 1'b0, HSIZE_WORD, 0, 1'b0, 1'b1, 1,  0};
      tbl[4]  = '{BASE - 32'h4,   1'b1, HSIZE_WORD, 0,  1'b0, 1'b1, 1,  0};
      tbl[5]  = '{BASE + 32'h031, 1'b0, HSIZE_HALF, 0,  1'b0, 1'b1, 1,  0};
      tbl[6]  = '{BASE + 32'h033, 1'b0, HSIZE_BYTE, 1,  1'b0, 1'b0, 2,  2};
      tbl[7]  = '{BASE + 32'h040, 1'b1, 3'd3,       0,  1'b0, 1'b1, 1,  0};
      tbl[8]  = '{BASE + 32'h044, 1'b0, HSIZE_WORD, 0,  1'b1, 1'b1, 2,  1};
      tbl[9]  = '{BASE + 32'h048, 1'b0, HSIZE_WORD, 14, 1'b0, 1'b0, 15, 15};
      tbl[10] = '{BASE + 32'h04C, 1'b0, HSIZE_WORD, 99, 1'b0, 1'b1, 16, 15};
      tbl[11] = '{BASE + 32'hFFE, 1'b0, HSIZE_HALF, 0,  1'b0, 1'b0, 1,  1};
      tbl[12] = '{BASE + 32'h050, 1'b1, HSIZE_WORD, 1,  1'b1, 1'b1, 3,  2};

      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0; HSIZE = '0; HWDATA = '0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      rst_checks("reset");
      @(posedge HCLK);
      #1 HRESETn = 1'b1;

      for (int i = 0; i < 13; i++)
         xfer(tbl[i].addr, tbl[i].wr, tbl[i].sz, 32'hDEAD_BEEF ^ 32'(i), tbl[i].dly,
              tbl[i].berr, tbl[i].fault, tbl[i].lo, tbl[i].req);

      for (int i = 0; i < 40; i++) begin
         a    = BASE - 32'd16 + 32'($urandom_range(0, WIN + 32));
         sz   = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
         dly  = $urandom_range(0, 17);
         berr = ($urandom_range(0, 4) == 0);
         model(a, sz, dly, berr, m_fault, m_lo, m_req);
         xfer(a, 1'($urandom), sz, $urandom, dly, berr, m_fault, m_lo, m_req);
      end

      burst(1'b1, BASE + 32'h100, 0);
      burst(1'b0, BASE + 32'h200, 3);

      be_stray = 1'b1;
      repeat (4) begin
         @(negedge HCLK);
         chk("stray_hreadyout", {31'b0, HREADYOUT}, 32'd1);
         chk("stray_hrdata",    HRDATA,             exp_hrdata);
      end
      @(posedge HCLK);
      #1 be_stray = 1'b0;

      xfer(BASE + 32'h060, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 1'b0, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
